// File: rtl/pwm_ramp_ctrl.sv
// rtl/pwm_ramp_ctrl.sv - pwm configuration sequencer with overflow-aligned soft duty ramp
//
// Purpose: latches duty/prescaler/clear button edges into target settings and
// pushes them to the pwm only on overflow boundaries. ccr slews toward the
// target duty by at most RAMP_STEP per applied boundary.
//
// Optional feature macro: PWM_RAMP_CTRL_WDOG_EN
//   defined   - a PEND watchdog forces an apply after WDOG_CYCLES clocks without
//               an overflow and sets the sticky wdog_flag
//   undefined - PEND waits for an overflow indefinitely, wdog_flag tied 0
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   duty_btn, psc_btn, clr_btn  debounced button levels (rising edge = command)
//   ovf                         pwm overflow flag (rising edge = period boundary)
//   ccr, psc, top               compare / prescaler / period top to the pwm
//   pwm_cf_reg                  pwm config (enable, count up)
//   busy                        an update is outstanding
//   wdog_flag                   sticky watchdog indication

module pwm_ramp_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int DUTY_STEP   = 25,
    parameter int RAMP_STEP   = 1,
    parameter int TOP_VAL     = 255,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  duty_btn,
    input  logic                  psc_btn,
    input  logic                  clr_btn,
    input  logic                  ovf,
    output logic [DATA_WIDTH-1:0] ccr,
    output logic [DATA_WIDTH-1:0] psc,
    output logic [DATA_WIDTH-1:0] top,
    output logic [7:0]            pwm_cf_reg,
    output logic                  busy,
    output logic                  wdog_flag
);

    localparam logic [DATA_WIDTH-1:0] DUTY_STEP_W = DATA_WIDTH'(DUTY_STEP);
    localparam logic [DATA_WIDTH-1:0] RAMP_STEP_W = DATA_WIDTH'(RAMP_STEP);

    // Reject degenerate configurations at elaboration.
    if (RAMP_STEP < 1 || WDOG_CYCLES < 2) begin : g_bad_param
        $error("pwm_ramp_ctrl: RAMP_STEP must be >= 1 and WDOG_CYCLES >= 2");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        APPLY = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  duty_btn_q, psc_btn_q, clr_btn_q, ovf_q;
    logic [DATA_WIDTH-1:0] ccr_q, ccr_d;
    logic [DATA_WIDTH-1:0] psc_q, psc_d;
    logic [DATA_WIDTH-1:0] target_q, target_d;
    logic [DATA_WIDTH-1:0] psc_pend_q, psc_pend_d;
    logic                  psc_dirty_q, psc_dirty_d;

    logic                  duty_rise, psc_rise, clr_rise, ovf_rise;
    logic [DATA_WIDTH-1:0] ccr_step;
    logic [DATA_WIDTH-1:0] psc_next;
    logic [DATA_WIDTH+1:0] psc_x4;

`ifdef PWM_RAMP_CTRL_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic              wdog_flag_q, wdog_flag_d;
`endif

    assign duty_rise = duty_btn & ~duty_btn_q;
    assign psc_rise  = psc_btn  & ~psc_btn_q;
    assign clr_rise  = clr_btn  & ~clr_btn_q;
    assign ovf_rise  = ovf      & ~ovf_q;

    // Prescaler sequence 0 -> 4 -> x4 ... ; anything past full scale folds to 0.
    assign psc_x4 = {psc_pend_q, 2'b00};
    always_comb begin
        psc_next = '0;
        if (psc_pend_q == '0) begin
            psc_next = DATA_WIDTH'(4);
        end else if (psc_x4[DATA_WIDTH+1:DATA_WIDTH] == 2'b00) begin
            psc_next = psc_x4[DATA_WIDTH-1:0];
        end
    end

    // One ramp step toward the target. Compare magnitudes first so ccr never
    // overshoots the target and never wraps through zero or full scale.
    always_comb begin
        ccr_step = ccr_q;
        if (target_q > ccr_q) begin
            if ((target_q - ccr_q) <= RAMP_STEP_W) ccr_step = target_q;
            else                                    ccr_step = ccr_q + RAMP_STEP_W;
        end else if (target_q < ccr_q) begin
            if ((ccr_q - target_q) <= RAMP_STEP_W) ccr_step = target_q;
            else                                    ccr_step = ccr_q - RAMP_STEP_W;
        end
    end

    always_comb begin
        state_d     = state_q;
        ccr_d       = ccr_q;
        psc_d       = psc_q;
        target_d    = target_q;
        psc_pend_d  = psc_pend_q;
        psc_dirty_d = psc_dirty_q;
`ifdef PWM_RAMP_CTRL_WDOG_EN
        wdog_cnt_d  = '0;
        wdog_flag_d = wdog_flag_q;
`endif

        case (state_q)
            IDLE: begin
                if ((ccr_q != target_q) || psc_dirty_q) state_d = PEND;
            end
            PEND: begin
`ifdef PWM_RAMP_CTRL_WDOG_EN
                if (ovf_rise) begin
                    state_d = APPLY;
                end else if (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1)) begin
                    state_d     = APPLY;
                    wdog_flag_d = 1'b1;
                end else begin
                    wdog_cnt_d = wdog_cnt_q + 1'b1;
                end
`else
                if (ovf_rise) state_d = APPLY;
`endif
            end
            APPLY: begin
                ccr_d = ccr_step;
                if (psc_dirty_q) begin
                    psc_d       = psc_pend_q;
                    psc_dirty_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Commands are applied after the FSM so a same-cycle command re-marks
        // the prescaler dirty even while APPLY is consuming the old value.
        if (clr_rise) begin
            target_d    = '0;
            psc_pend_d  = '0;
            psc_dirty_d = 1'b1;
        end else begin
            if (duty_rise) target_d = target_q + DUTY_STEP_W;
            if (psc_rise) begin
                psc_pend_d  = psc_next;
                psc_dirty_d = 1'b1;
            end
        end

        if (state_q == APPLY) begin
            state_d = ((ccr_d == target_d) && !psc_dirty_d) ? IDLE : PEND;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            duty_btn_q  <= 1'b0;
            psc_btn_q   <= 1'b0;
            clr_btn_q   <= 1'b0;
            ovf_q       <= 1'b0;
            ccr_q       <= '0;
            psc_q       <= '0;
            target_q    <= '0;
            psc_pend_q  <= '0;
            psc_dirty_q <= 1'b0;
`ifdef PWM_RAMP_CTRL_WDOG_EN
            wdog_cnt_q  <= '0;
            wdog_flag_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            duty_btn_q  <= duty_btn;
            psc_btn_q   <= psc_btn;
            clr_btn_q   <= clr_btn;
            ovf_q       <= ovf;
            ccr_q       <= ccr_d;
            psc_q       <= psc_d;
            target_q    <= target_d;
            psc_pend_q  <= psc_pend_d;
            psc_dirty_q <= psc_dirty_d;
`ifdef PWM_RAMP_CTRL_WDOG_EN
            wdog_cnt_q  <= wdog_cnt_d;
            wdog_flag_q <= wdog_flag_d;
`endif
        end
    end

    assign ccr        = ccr_q;
    assign psc        = psc_q;
    assign top        = DATA_WIDTH'(TOP_VAL);
    assign pwm_cf_reg = 8'h03;
    assign busy       = (state_q != IDLE);
`ifdef PWM_RAMP_CTRL_WDOG_EN
    assign wdog_flag  = wdog_flag_q;
`else
    assign wdog_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb/tb_pwm_ramp_ctrl.sv - directed self-checking bench for pwm_ramp_ctrl

module tb_pwm_ramp_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       duty_btn, psc_btn, clr_btn, ovf;
    logic [7:0] ccr, psc, top, pwm_cf_reg;
    logic       busy, wdog_flag;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pwm_ramp_ctrl #(
        .DATA_WIDTH (8),
        .DUTY_STEP  (25),
        .RAMP_STEP  (5),
        .TOP_VAL    (255),
        .WDOG_CYCLES(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .duty_btn  (duty_btn),
        .psc_btn   (psc_btn),
        .clr_btn   (clr_btn),
        .ovf       (ovf),
        .ccr       (ccr),
        .psc       (psc),
        .top       (top),
        .pwm_cf_reg(pwm_cf_reg),
        .busy      (busy),
        .wdog_flag (wdog_flag)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic d, input logic p, input logic c);
        duty_btn = d;
        psc_btn  = p;
        clr_btn  = c;
        tick();
        duty_btn = 1'b0;
        psc_btn  = 1'b0;
        clr_btn  = 1'b0;
        tick();
    endtask

    task automatic ovf_pulse();
        ovf = 1'b1;
        tick();
        ovf = 1'b0;
        tick();
    endtask

    task automatic check_outputs_reset(input string tag);
        check_eq({tag, "_ccr"},  int'(ccr), 0);
        check_eq({tag, "_psc"},  int'(psc), 0);
        check_eq({tag, "_busy"}, int'(busy), 0);
        check_eq({tag, "_top"},  int'(top), 255);
        check_eq({tag, "_cf"},   int'(pwm_cf_reg), 3);
        check_eq({tag, "_wdog"}, int'(wdog_flag), 0);
    endtask

    initial begin
        rst      = 1'b1;
        duty_btn = 1'b0;
        psc_btn  = 1'b0;
        clr_btn  = 1'b0;
        ovf      = 1'b0;
        tick();
        tick();
        check_outputs_reset("rst_init");
        rst = 1'b0;
        tick();

        // Single duty step to 25, ramp 5 per boundary, each visible 2 edges after ovf.
        press(1'b1, 1'b0, 1'b0);
        check_eq("duty_busy", int'(busy), 1);
        check_eq("duty_hold", int'(ccr), 0);
        for (int i = 1; i <= 5; i++) begin
            ovf_pulse();
            check_eq($sformatf("ramp_up_%0d", i), int'(ccr), 5 * i);
        end
        check_eq("ramp_up_idle", int'(busy), 0);

        // ovf while idle is ignored.
        ovf_pulse();
        check_eq("idle_ovf_ccr", int'(ccr), 25);
        check_eq("idle_ovf_busy", int'(busy), 0);

        // Prescaler sequence 4,16,64,0; psc only moves on a boundary.
        begin
            int psc_exp[4] = '{4, 16, 64, 0};
            int psc_prev = 0;
            foreach (psc_exp[i]) begin
                press(1'b0, 1'b1, 1'b0);
                check_eq($sformatf("psc_hold_%0d", i), int'(psc), psc_prev);
                ovf_pulse();
                check_eq($sformatf("psc_apply_%0d", i), int'(psc), psc_exp[i]);
                psc_prev = psc_exp[i];
            end
        end
        check_eq("psc_idle", int'(busy), 0);

        // Target 50, then duty+clr together: clear wins, ramp down to 0.
        press(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) ovf_pulse();
        check_eq("ramp_to_50", int'(ccr), 50);
        press(1'b1, 1'b0, 1'b1);
        ovf_pulse();
        check_eq("clr_first", int'(ccr), 45);
        check_eq("clr_psc", int'(psc), 0);
        for (int i = 0; i < 9; i++) ovf_pulse();
        check_eq("clr_done", int'(ccr), 0);
        check_eq("clr_busy", int'(busy), 0);

        // Target 250, then wrap to 19 and ramp downward (231 = 46*5 + 1).
        for (int i = 0; i < 10; i++) press(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 50; i++) ovf_pulse();
        check_eq("ramp_to_250", int'(ccr), 250);
        check_eq("at_250_busy", int'(busy), 0);
        press(1'b1, 1'b0, 1'b0);
        check_eq("wrap_busy", int'(busy), 1);
        ovf_pulse();
        check_eq("wrap_first", int'(ccr), 245);
        for (int i = 0; i < 45; i++) ovf_pulse();
        check_eq("wrap_near", int'(ccr), 20);
        ovf_pulse();
        check_eq("wrap_done", int'(ccr), 19);
        check_eq("wrap_busy_end", int'(busy), 0);

        // Target 44 with no overflow for a long stretch.
        press(1'b1, 1'b0, 1'b0);
`ifdef PWM_RAMP_CTRL_WDOG_EN
        for (int i = 0; i < 15; i++) tick();
        check_eq("wdog_pre_flag", int'(wdog_flag), 0);
        tick();
        check_eq("wdog_flag_set", int'(wdog_flag), 1);
        check_eq("wdog_pre_ccr", int'(ccr), 19);
        tick();
        check_eq("wdog_apply_ccr", int'(ccr), 24);
`else
        for (int i = 0; i < 40; i++) tick();
        check_eq("pend_wait_ccr", int'(ccr), 19);
        check_eq("pend_wait_busy", int'(busy), 1);
        check_eq("pend_wait_wdog", int'(wdog_flag), 0);
        ovf_pulse();
        check_eq("pend_ovf_ccr", int'(ccr), 24);
`endif

        // duty+psc in the same cycle both land; second psc step to 16.
        press(1'b1, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        ovf_pulse();
        check_eq("dual_ccr", int'(ccr), 29);
        check_eq("dual_psc", int'(psc), 16);
        check_eq("dual_busy", int'(busy), 1);
`ifdef PWM_RAMP_CTRL_WDOG_EN
        check_eq("wdog_sticky", int'(wdog_flag), 1);
`endif

        // Asynchronous reset mid-operation, checked before the next clock edge.
        rst = 1'b1;
        #1;
        check_outputs_reset("rst_async");
        tick();
        rst = 1'b0;
        tick();
        tick();
        check_outputs_reset("rst_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
